// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU bus responder.
//   bus_state_t  : responder FSM states
//   OAMDMA_ADDR  : write here to start a 256-byte page copy into OAM
//   RAM_TOP      : highest CPU address decoded to work RAM (mirrored below it)
//   DMA_FILL     : byte delivered for DMA source pages outside RAM
package cpu_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACK,
        DMA_ALIGN,
        DMA_RD,
        DMA_WR
    } bus_state_t;

    localparam logic [15:0] OAMDMA_ADDR = 16'h4014;
    localparam logic [15:0] RAM_TOP     = 16'h1FFF;
    localparam logic [7:0]  DMA_FILL    = 8'hFF;

    // True when a CPU address lands in the mirrored work-RAM window.
    function automatic logic is_ram_addr(input logic [15:0] a);
        return a <= RAM_TOP;
    endfunction

endpackage

// File: rtl/cpu_ram.sv
// Single-port synchronous work RAM with registered read data.
//   clk   : system clock
//   we    : write enable (write occurs on posedge)
//   addr  : byte index
//   wdata : write data
//   rdata : data of the location addressed on the previous edge
// Contents are intentionally not reset.
module cpu_ram
    import cpu_bus_pkg::*;
#(
    parameter int RAM_BYTES = 2048
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(RAM_BYTES)-1:0] addr,
    input  logic [7:0]                   wdata,
    output logic [7:0]                   rdata
);

    logic [7:0] mem [RAM_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/cpu_bus_responder.sv
// Memory-side responder for the 6502 data bus: mirrored work RAM, open-bus
// read latch, req/ack handshake with WAIT_CYCLES wait states, and the
// $4014 OAM DMA engine that stalls the CPU through rdy.
//   clk, rst_n         : clock, asynchronous active-low reset
//   req, we, addr,wdata: CPU request (held stable while req is high)
//   rdata, ack         : read data (valid during ack), one-cycle completion
//   rdy, dma_busy      : CPU stall (rdy low) while DMA runs; dma_busy = !rdy
//   oam_we/addr/data   : OAM byte write port driven by the DMA engine
module cpu_bus_responder
    import cpu_bus_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int RAM_BYTES   = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ack,
    output logic        rdy,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    output logic        dma_busy
);

    localparam int AW = $clog2(RAM_BYTES);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    bus_state_t     state, state_next;
    logic [CW-1:0]  wait_cnt;
    logic           cap_we;
    logic [15:0]    cap_addr;
    logic [7:0]     cap_wdata;
    logic [7:0]     page;
    logic [7:0]     idx;
    logic [7:0]     rdata_q;

    logic           ram_we;
    logic [AW-1:0]  ram_addr;
    logic [7:0]     ram_q;

    logic           cap_is_ram;
    logic           cap_is_dma;

    assign cap_is_ram = is_ram_addr(cap_addr);
    assign cap_is_dma = cap_we && (cap_addr == OAMDMA_ADDR);

    // State register and the datapath registers that follow it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            page      <= '0;
            idx       <= '0;
            rdata_q   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req) begin
                        cap_we    <= we;
                        cap_addr  <= addr;
                        cap_wdata <= wdata;
                        wait_cnt  <= CW'(WAIT_CYCLES);
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - CW'(1);
                end
                ACK: begin
                    // Open-bus latch: only RAM reads refresh it.
                    if (!cap_we && cap_is_ram) begin
                        rdata_q <= ram_q;
                    end
                end
                DMA_ALIGN: begin
                    page <= cap_wdata;
                    idx  <= '0;
                end
                DMA_WR: begin
                    idx <= idx + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic. WAIT occupies exactly WAIT_CYCLES cycles, so it
    // exits when the counter is about to reach zero.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = (WAIT_CYCLES > 0) ? WAIT : ACK;
                end
            end
            WAIT: begin
                if (wait_cnt == CW'(1)) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = cap_is_dma ? DMA_ALIGN : IDLE;
            end
            DMA_ALIGN: state_next = DMA_RD;
            DMA_RD:    state_next = DMA_WR;
            DMA_WR: begin
                state_next = (idx == 8'hFF) ? IDLE : DMA_RD;
            end
            default:   state_next = IDLE;
        endcase
    end

    // RAM port mux. In IDLE the live CPU address is presented so that the
    // registered read is ready by the ACK cycle even with zero wait states.
    always_comb begin
        ram_addr = cap_addr[AW-1:0];
        case (state)
            IDLE:                      ram_addr = addr[AW-1:0];
            DMA_ALIGN, DMA_RD, DMA_WR: ram_addr = AW'({page, idx});
            default:                   ram_addr = cap_addr[AW-1:0];
        endcase
    end

    assign ram_we = (state == ACK) && cap_we && cap_is_ram;

    cpu_ram #(
        .RAM_BYTES(RAM_BYTES)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (cap_wdata),
        .rdata (ram_q)
    );

    // Outputs decode from state so reset drops them without a clock edge.
    assign ack      = (state == ACK);
    assign rdata    = (ack && !cap_we && cap_is_ram) ? ram_q : rdata_q;
    assign rdy      = (state == IDLE) || (state == WAIT) || (state == ACK);
    assign dma_busy = !rdy;
    assign oam_we   = (state == DMA_WR);
    assign oam_addr = idx;
    assign oam_data = (state == DMA_WR) ?
                      ((page <= RAM_TOP[15:8]) ? ram_q : DMA_FILL) : 8'h00;

endmodule

// File: tb/tb_cpu_bus_responder.sv
module tb_cpu_bus_responder;

    localparam int W = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req = 1'b0, we = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata, oam_addr, oam_data;
    logic        ack, rdy, oam_we, dma_busy;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [15:0] addr0 = '0;
    logic [7:0]  wdata0 = '0;
    logic [7:0]  rdata0, oam_addr0, oam_data0;
    logic        ack0, rdy0, oam_we0, dma_busy0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 2 KB RAM image plus the open-bus byte.
    logic [7:0] mem_m [2048];
    logic [7:0] ob;

    always #5 clk = ~clk;

    cpu_bus_responder #(.WAIT_CYCLES(W), .RAM_BYTES(2048)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .rdy(rdy), .oam_we(oam_we), .oam_addr(oam_addr),
        .oam_data(oam_data), .dma_busy(dma_busy)
    );

    cpu_bus_responder #(.WAIT_CYCLES(0), .RAM_BYTES(2048)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .ack(ack0), .rdy(rdy0), .oam_we(oam_we0), .oam_addr(oam_addr0),
        .oam_data(oam_data0), .dma_busy(dma_busy0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdata"},    32'(rdata),    32'h0);
        check({tag, "_ack"},      32'(ack),      32'h0);
        check({tag, "_rdy"},      32'(rdy),      32'h1);
        check({tag, "_oam_we"},   32'(oam_we),   32'h0);
        check({tag, "_oam_addr"}, 32'(oam_addr), 32'h0);
        check({tag, "_oam_data"}, 32'(oam_data), 32'h0);
        check({tag, "_dma_busy"}, 32'(dma_busy), 32'h0);
    endtask

    // One CPU access on the W-wait-state instance; returns at the negedge of
    // the ack cycle with req already dropped. lat = -1 on timeout.
    task automatic access(input logic w, input logic [15:0] a, input logic [7:0] d,
                          output int lat, output logic [7:0] rd);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        lat = -1;
        rd  = 8'h00;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (ack) begin
                lat = n;
                rd  = rdata;
                break;
            end
        end
        req = 1'b0; we = 1'b0;
    endtask

    task automatic bus_op(input string tag, input logic w, input logic [15:0] a, input logic [7:0] d);
        int lat;
        logic [7:0] rd, exp;
        access(w, a, d, lat, rd);
        check({tag, "_latency"}, 32'(lat), 32'(W + 1));
        exp = ob;
        if (a <= 16'h1FFF) begin
            if (w) mem_m[a[10:0]] = d;
            else begin
                exp = mem_m[a[10:0]];
                ob  = exp;
            end
        end
        if (!w) check({tag, "_rdata"}, 32'(rd), 32'(exp));
    endtask

    // Trigger a page copy and watch the whole DMA window from the ack cycle A.
    task automatic dma_run(input logic [7:0] p, input bit hold_req);
        int first_low = -1, low_cnt = 0, high_at = -1, pulses = 0;
        int back2back = 0, busy_bad = 0, ack_c = -1, early_ack = 0;
        logic prev_we = 1'b0;
        logic [7:0] kb, exp_d, held_rd = 8'h00;
        bus_op("dma_trigger", 1'b1, 16'h4014, p);
        for (int c = 1; c <= 540; c++) begin
            if (hold_req && c == 10) begin
                req = 1'b1; we = 1'b0; addr = 16'h0123;
            end
            @(negedge clk);
            if (dma_busy !== !rdy) busy_bad++;
            if (!rdy) begin
                low_cnt++;
                if (first_low < 0) first_low = c;
            end else if (first_low >= 0 && high_at < 0) begin
                high_at = c;
            end
            if (oam_we) begin
                if (prev_we) back2back++;
                kb    = pulses[7:0];
                exp_d = (p <= 8'h1F) ? mem_m[{p[2:0], kb}] : 8'hFF;
                if (pulses < 256) begin
                    check("dma_pulse_time", 32'(c), 32'(3 + 2 * pulses));
                    check("dma_oam_addr", 32'(oam_addr), 32'(kb));
                    check("dma_oam_data", 32'(oam_data), 32'(exp_d));
                end
                pulses++;
            end
            prev_we = oam_we;
            if (ack && hold_req && ack_c < 0) begin
                if (c <= 513) early_ack++;
                ack_c   = c;
                held_rd = rdata;
                req = 1'b0;
            end
        end
        check("dma_rdy_fall", 32'(first_low), 32'd1);
        check("dma_rdy_low_cycles", 32'(low_cnt), 32'd513);
        check("dma_rdy_rise", 32'(high_at), 32'd514);
        check("dma_pulse_count", 32'(pulses), 32'd256);
        check("dma_oam_we_consecutive", 32'(back2back), 32'd0);
        check("dma_busy_vs_rdy", 32'(busy_bad), 32'd0);
        if (hold_req) begin
            check("held_req_early_ack", 32'(early_ack), 32'd0);
            check("held_req_ack_cycle", 32'(ack_c), 32'(514 + W + 1));
            check("held_req_rdata", 32'(held_rd), 32'(mem_m[11'h123]));
            ob = mem_m[11'h123];
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int found, we_cnt, lowc;
        int acks0 [$];
        logic [15:0] a;
        ob = 8'h00;

        // Reset state.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        check("reset0_rdy", 32'(rdy0), 32'h1);
        check("reset0_ack", 32'(ack0), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read through a mirror.
        bus_op("wr_0123", 1'b1, 16'h0123, 8'h5A);
        bus_op("rd_0923", 1'b0, 16'h0923, 8'h00);

        // Fill page 0 randomly and page 2 with a known pattern.
        for (int i = 0; i < 256; i++)
            bus_op("fill_p0", 1'b1, {8'h00, 8'(i)}, 8'($urandom));
        for (int i = 0; i < 256; i++)
            bus_op("fill_p2", 1'b1, {8'h02, 8'(i)}, 8'(i) ^ 8'hA5);

        // Open bus behaviour.
        bus_op("wr_0000", 1'b1, 16'h0000, 8'h11);
        bus_op("rd_0000", 1'b0, 16'h0000, 8'h00);
        bus_op("rd_5000_openbus", 1'b0, 16'h5000, 8'h00);
        bus_op("wr_5000_dropped", 1'b1, 16'h5000, 8'h77);
        bus_op("rd_1000_mirror", 1'b0, 16'h1000, 8'h00);
        @(negedge clk);
        check("rdata_hold_idle", 32'(rdata), 32'(ob));

        // Random traffic over mirrored RAM pages 0/2 and unmapped space.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = 16'h2000 + 16'($urandom_range(0, 16'hDFFF));
                if (a == 16'h4014) a = 16'h4015;
            end else begin
                a = {3'b000, 2'($urandom), ($urandom_range(0, 1) == 1) ? 3'd2 : 3'd0, 8'($urandom)};
            end
            bus_op("random", 1'($urandom), a, 8'($urandom));
        end

        // DMA from RAM page 2, then from an unmapped page with a held request.
        dma_run(8'h02, 1'b0);
        check("rdata_after_dma", 32'(rdata), 32'(ob));
        dma_run(8'h80, 1'b1);

        // Reset in the middle of a DMA.
        bus_op("dma_trigger_rst", 1'b1, 16'h4014, 8'h02);
        found = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (oam_we && oam_addr == 8'h40) begin
                found = 1;
                break;
            end
        end
        check("mid_dma_reached_40", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        ob = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        we_cnt = 0;
        lowc = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (oam_we) we_cnt++;
            if (!rdy) lowc++;
        end
        check("post_reset_no_oam_we", 32'(we_cnt), 32'd0);
        check("post_reset_rdy_low", 32'(lowc), 32'd0);
        bus_op("post_reset_rd_0123", 1'b0, 16'h0123, 8'h00);

        // Zero wait states, back-to-back with req held high.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0000; wdata0 = 8'h11;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (ack0) begin
                acks0.push_back(n);
                if (acks0.size() == 1) we0 = 1'b0;
                else begin
                    check("w0_read_rdata", 32'(rdata0), 32'h11);
                    req0 = 1'b0;
                end
            end
        end
        check("w0_ack_count", 32'(acks0.size()), 32'd2);
        if (acks0.size() == 2) begin
            check("w0_first_ack", 32'(acks0[0]), 32'd1);
            check("w0_second_ack", 32'(acks0[1]), 32'd3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_bus_responder.md
# cpu_bus_responder

Memory-side responder for the 6502 core's data bus. It serves CPU read/write requests through a req/ack handshake with a configurable number of wait states. It holds the 2 KB internal work RAM, mirrored across $0000-$1FFF, and implements the $4014 OAM DMA engine. The DMA engine stalls the CPU through `rdy` while it copies one 256-byte page into PPU OAM.

## Interface
- `WAIT_CYCLES`, 1, extra cycles between request capture and `ack`; 0 is legal.
- `RAM_BYTES`, 2048, internal RAM size; power of two; index is `addr[$clog2(RAM_BYTES)-1:0]`.
- `clk`  in  1  single system clock; all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  CPU access request; `addr`/`we`/`wdata` stable while high.
- `we`  in  1  1 = write, 0 = read.
- `addr`  in  16  CPU address.
- `wdata`  in  8  write data.
- `rdata`  out  8  read data, valid in the `ack` cycle; holds last value otherwise (open-bus latch).
- `ack`  out  1  one-cycle completion pulse.
- `rdy`  out  1  0 = CPU must stall (DMA in progress).
- `oam_we`  out  1  OAM write strobe, one cycle per byte.
- `oam_addr`  out  8  OAM byte index.
- `oam_data`  out  8  OAM write data.
- `dma_busy`  out  1  equals `!rdy`.

## Operation
- Address map:
  - $0000-$1FFF: RAM at `addr[10:0]`.
  - $4014 write: DMA trigger.
  - Everything else: unmapped. Reads return the current `rdata` latch (open bus) and writes are dropped. Both still complete with `ack`.
- FSM states: IDLE, WAIT, ACK, DMA_ALIGN, DMA_RD, DMA_WR.
- IDLE:
  - `req` high and `rdy` high: capture `addr`/`we`/`wdata` and load the wait counter with `WAIT_CYCLES`.
  - Go to WAIT if `WAIT_CYCLES > 0`, else go to ACK.
- WAIT: counter decrements each cycle; at 0 go to ACK.
- ACK:
  - `ack` = 1 and `rdata` is updated for reads.
  - The RAM write is committed in this cycle.
  - If the access was a $4014 write, go to DMA_ALIGN. Otherwise go to IDLE.
  - If `req` is still high in IDLE on the next cycle, that is a new transaction (back-to-back).
- $4014 write with value P:
  - DMA_ALIGN (1 cycle): page latched and `i` = 0.
  - DMA_RD: read source byte at `{P,i}`.
  - DMA_WR: `oam_we` = 1, `oam_addr` = `i`, `oam_data` = that byte; `i` increments.
  - DMA_RD and DMA_WR alternate 256 times, then return to IDLE.
- DMA source: if P < $20, read RAM at `{P[2:0],i}` (mirrored). Otherwise the byte is 8'hFF, since no cartridge is attached to this block.
- `rdy` = 0 in the DMA_* states. `req` is ignored there; a request held high is accepted in the first IDLE cycle after DMA ends.
- The RAM is single-port. The CPU path and DMA path never overlap, so no arbitration is needed.
- The 8-bit index `i` counts 0-255. A DMA_WR with `i` = 255 terminates the copy; the wrap to 0 is not used.

## Timing
- Reset values: `rdata` = 0, `ack` = 0, `rdy` = 1, `oam_we` = 0, `oam_addr` = 0, `oam_data` = 0, `dma_busy` = 0, FSM = IDLE. RAM contents are not reset.
- Read/write latency: `req` sampled at edge N gives `ack` high in cycle N+WAIT_CYCLES+1.
- `rdata` changes only in the `ack` cycle of a read.
- DMA timing, with the $4014 `ack` in cycle A:
  - `rdy` falls in cycle A+1.
  - First `oam_we` pulse is in cycle A+3.
  - Last `oam_we` pulse (`oam_addr` = 255) is in cycle A+513.
  - `rdy` rises in cycle A+514.
  - `rdy` is low for exactly 513 cycles.
- `oam_we` is never high in two consecutive cycles.
- Reset mid-transaction or mid-DMA aborts immediately. `oam_we`/`ack` drop asynchronously; OAM writes already issued stand.

## Structure
- Package `cpu_bus_pkg`: state enum `bus_state_t`, `OAMDMA_ADDR` = 16'h4014, `RAM_TOP` = 16'h1FFF, `DMA_FILL` = 8'hFF.
- Sub-module `cpu_ram`: single-port synchronous RAM, `RAM_BYTES` x 8, registered read, write-enable port. The address and data muxes between the CPU path and DMA path live in the parent.

## Test plan
- `WAIT_CYCLES` = 1: write $0123 = 8'h5A, then read $0923 (mirror) -> `ack` 2 cycles after each request, read `rdata` = 8'h5A.
- `WAIT_CYCLES` = 0, `req` held high across write $0000 = 8'h11 then read $0000 -> `ack` on consecutive-but-one cycles, `rdata` = 8'h11.
- Read $5000 right after reading 8'h11 -> `ack` asserted, `rdata` stays 8'h11 (open bus); write $5000 leaves RAM unchanged.
- Fill $0200-$02FF with `i^8'hA5`, write $4014 = 8'h02 -> `rdy` low 513 cycles, 256 `oam_we` pulses, `oam_data` for `oam_addr` k = `k^8'hA5`, `rdy` high at A+514.
- Write $4014 = 8'h80 -> 256 OAM writes of 8'hFF; `req` raised during DMA -> no `ack` until the cycle after `rdy` returns, then normal latency.
- Assert `rst_n` = 0 at `oam_addr` = 8'h40 mid-DMA -> outputs at reset values immediately, `rdy` = 1, no further `oam_we`.
